fft_frame_collector: RTL

Parametrised input-side successor to the current FFT/OFDM DUT interface. It accepts the same signed complex sample stream (Pushin/FirstData/DinR/DinI), assembles complete NPTS-point frames into a ping-pong buffer, and drains each frame in natural or bit-reversed order over a ready/valid port with backpressure. It sits between the stimulus/upstream stream and the FFT core, and detects resync and overflow conditions.

---
 rtl/fft_collector_pkg.sv | 20 ++
 rtl/fft_pingpong_ram.sv | 26 ++
 rtl/fft_frame_collector.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_collector_pkg.sv
// Shared types, defaults and helpers for the FFT frame collector.
package fft_collector_pkg;

  localparam int unsigned DW_DEFAULT   = 17;
  localparam int unsigned NPTS_DEFAULT = 128;

  typedef enum logic {WIdle, WFill} wr_state_e;
  typedef enum logic {RIdle, RDrain} rd_state_e;

  // Reverse the low log2n bits of idx.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned log2n);
    int unsigned rev;
    rev = 0;
    for (int unsigned b = 0; b < log2n; b++) begin
      rev = (rev << 1) | ((idx >> b) & 32'd1);
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Simple dual-port synchronous RAM holding two frames, addressed {bank, index}.
module fft_pingpong_ram #(
  parameter int unsigned DW = 17,
  parameter int unsigned NPTS = 128,
  localparam int unsigned AW = $clog2(2 * NPTS)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [2*DW-1:0] wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [2*DW-1:0] rdata_o
);

  logic [2*DW-1:0] mem [2*NPTS];
  logic [2*DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_collector.sv
// Collects NPTS-point complex frames into a ping-pong buffer and drains them
// in natural or bit-reversed order over a ready/valid port.
module fft_frame_collector import fft_collector_pkg::*; #(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned NPTS = NPTS_DEFAULT,
  parameter bit BITREV = 1'b0,
  localparam int unsigned LOG2N = $clog2(NPTS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Pushin,
  input  logic             FirstData,
  input  logic [DW-1:0]    DinR,
  input  logic [DW-1:0]    DinI,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [DW-1:0]    OutR,
  output logic [DW-1:0]    OutI,
  output logic [LOG2N-1:0] OutIndex,
  output logic             OutFirst,
  output logic             OutLast,
  output logic             FrameErr,
  output logic             Overflow
);

  localparam int unsigned EW = 2 * DW + LOG2N + 2;
  localparam logic [LOG2N-1:0] LastIdx = LOG2N'(NPTS - 1);

  wr_state_e        wstate_q, wstate_d;
  logic             wb_q, wb_d;
  logic [LOG2N-1:0] widx_q, widx_d, waddr_idx;
  logic [1:0]       full_q, full_d;
  logic             we, set_full;
  logic             frame_err_q, frame_err_d, overflow_q, overflow_d;

  rd_state_e        rstate_q, rstate_d;
  logic             rb_q, rb_d, fb_q;
  logic [LOG2N-1:0] ridx_q, ridx_d, raddr_idx;
  logic             issue, can_issue, pop, release_bank;
  logic [1:0]       occ;

  logic [2*DW-1:0]  rdata;
  logic             rd_valid_q, skid_valid_q, out_valid_q;
  logic [LOG2N+1:0] rd_meta_q;
  logic [EW-1:0]    rd_entry, skid_q, out_q;

  always_comb begin
    wstate_d    = wstate_q;
    wb_d        = wb_q;
    widx_d      = widx_q;
    waddr_idx   = widx_q;
    we          = 1'b0;
    set_full    = 1'b0;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    case (wstate_q)
      WIdle: begin
        if (Pushin && FirstData) begin
          if (full_q[wb_q]) begin
            overflow_d = 1'b1;
          end else begin
            we        = 1'b1;
            waddr_idx = '0;
            widx_d    = LOG2N'(1);
            wstate_d  = WFill;
          end
        end
      end
      WFill: begin
        if (Pushin) begin
          we = 1'b1;
          if (FirstData) begin
            frame_err_d = 1'b1;
            waddr_idx   = '0;
            widx_d      = LOG2N'(1);
          end else if (widx_q == LastIdx) begin
            set_full = 1'b1;
            wb_d     = ~wb_q;
            widx_d   = '0;
            wstate_d = WIdle;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      default: wstate_d = WIdle;
    endcase
  end

  // Reads are issued ahead of the handshake; at most two samples sit beyond the RAM.
  assign pop          = out_valid_q && OutReady;
  assign occ          = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_valid_q);
  assign can_issue    = (occ - 2'(pop)) < 2'd2;
  assign raddr_idx    = BITREV ? LOG2N'(bitrev(32'(ridx_q), LOG2N)) : ridx_q;
  // fb_q tracks the bank whose last sample is next to be accepted downstream.
  assign release_bank = pop && out_q[EW-1];

  always_comb begin
    rstate_d = rstate_q;
    rb_d     = rb_q;
    ridx_d   = ridx_q;
    issue    = 1'b0;
    case (rstate_q)
      RIdle: begin
        if (full_q[rb_q]) begin
          rstate_d = RDrain;
          issue    = can_issue;
        end
      end
      RDrain:  issue = can_issue;
      default: rstate_d = RIdle;
    endcase
    if (issue) begin
      if (ridx_q == LastIdx) begin
        ridx_d   = '0;
        rb_d     = ~rb_q;
        rstate_d = full_q[~rb_q] ? RDrain : RIdle;
      end else begin
        ridx_d = ridx_q + 1'b1;
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wb_q] = 1'b1;
    if (release_bank) full_d[fb_q] = 1'b0;
  end

  assign rd_entry = {rd_meta_q, rdata};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wstate_q     <= WIdle;
      wb_q         <= 1'b0;
      widx_q       <= '0;
      full_q       <= '0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      rstate_q     <= RIdle;
      rb_q         <= 1'b0;
      ridx_q       <= '0;
      fb_q         <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_meta_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      wstate_q    <= wstate_d;
      wb_q        <= wb_d;
      widx_q      <= widx_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      rstate_q    <= rstate_d;
      rb_q        <= rb_d;
      ridx_q      <= ridx_d;
      if (release_bank) fb_q <= ~fb_q;
      rd_valid_q <= issue;
      if (issue) rd_meta_q <= {ridx_q == LastIdx, ridx_q == '0, raddr_idx};
      if (!out_valid_q || OutReady) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_q        <= skid_q;
          skid_valid_q <= rd_valid_q;
          if (rd_valid_q) skid_q <= rd_entry;
        end else begin
          out_valid_q <= rd_valid_q;
          if (rd_valid_q) out_q <= rd_entry;
        end
      end else if (rd_valid_q) begin
        skid_valid_q <= 1'b1;
        skid_q       <= rd_entry;
      end
    end
  end

  fft_pingpong_ram #(
    .DW   (DW),
    .NPTS (NPTS)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (we),
    .waddr_i ({wb_q, waddr_idx}),
    .wdata_i ({DinR, DinI}),
    .re_i    (issue),
    .raddr_i ({rb_q, raddr_idx}),
    .rdata_o (rdata)
  );

  assign OutValid = out_valid_q;
  assign OutI     = out_q[DW-1:0];
  assign OutR     = out_q[2*DW-1:DW];
  assign OutIndex = out_q[2*DW +: LOG2N];
  assign OutFirst = out_q[EW-2];
  assign OutLast  = out_q[EW-1];
  assign FrameErr = frame_err_q;
  assign Overflow = overflow_q;

endmodule
